// File: rtl/kernel_weight_streamer.sv
// Producer side of the PE kernel-weight shift interface: streams NUM_KERNELS*KERNEL_SIZE
// words from the weight SRAM onto kernal with a per-word pe_ready strobe, then pulses done.
module kernel_weight_streamer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_KERNELS = 4,
    parameter int KERNEL_SIZE = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] kernal,
    output logic              pe_ready,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = NUM_KERNELS * KERNEL_SIZE;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    // cnt_r counts reads already issued, so base_r + cnt_r is the next address
    logic [CNT_W-1:0]  cnt_r;
    logic              rd_vld_r;
    logic [ADDR_W-1:0] next_addr_s;

    // Address of the next word; wraps modulo 2^ADDR_W
    assign next_addr_s = base_r + ADDR_W'(cnt_r);

    // Load sequencer: read issue, completion handshake and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            base_r    <= {ADDR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            mem_rd_en <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_r    <= base_addr;
                        cnt_r     <= CNT_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base_addr;
                        busy      <= 1'b1;
                        state_r   <= FETCH;
                    end else begin
                        mem_rd_en <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                FETCH: begin
                    // A stalled cycle still presents the next address so it is visibly frozen
                    if (cnt_r == LAST_CNT) begin
                        mem_rd_en <= 1'b0;
                        state_r   <= DRAIN;
                    end else if (hold) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= next_addr_s;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= next_addr_s;
                        cnt_r     <= cnt_r + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Pipeline empty means the last strobe is one cycle behind us;
                    // done then lands once the downstream parallel outputs have updated
                    if (!mem_rd_en && !rd_vld_r && !pe_ready) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Read-return pipeline: one cycle SRAM latency, then a registered strobe to the PE buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r <= 1'b0;
            kernal   <= {DATA_W{1'b0}};
            pe_ready <= 1'b0;
        end else begin
            rd_vld_r <= mem_rd_en;
            if (rd_vld_r) begin
                kernal   <= mem_rdata;
                pe_ready <= 1'b1;
            end else begin
                pe_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kernel_weight_streamer.sv
// Bench for kernel_weight_streamer: SRAM model, address/data scoreboard and
// per-cycle timing checks for each load scenario.
module tb_kernel_weight_streamer;

    localparam int TOTAL = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic [15:0] base_addr;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] kernal;
    logic        pe_ready;
    logic        busy;
    logic        done;

    kernel_weight_streamer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .kernal(kernal), .pe_ready(pe_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [0:65535];

    // SRAM model with one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] addr_q[$];
    logic [15:0] data_q[$];
    logic [15:0] got_q[$];
    logic [15:0] mon_exp;

    logic        rec_rd   [0:127];
    logic        rec_pe   [0:127];
    logic        rec_done [0:127];
    logic        rec_busy [0:127];
    logic [15:0] rec_addr [0:127];

    // Scoreboard monitor: every issued read and every strobed word against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_addr: read at %h, none expected", mem_addr);
                end else begin
                    mon_exp = addr_q.pop_front();
                    if (mem_addr !== mon_exp) begin
                        n_err++;
                        $display("FAIL sb_addr: got %h exp %h", mem_addr, mon_exp);
                    end
                end
            end
            if (pe_ready) begin
                n_cmp++;
                got_q.push_back(kernal);
                if (data_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_data: strobe with %h, none expected", kernal);
                end else begin
                    mon_exp = data_q.pop_front();
                    if (kernal !== mon_exp) begin
                        n_err++;
                        $display("FAIL sb_data: got %h exp %h", kernal, mon_exp);
                    end
                end
            end
        end
    end

    task automatic push_load(input logic [15:0] base);
        logic [15:0] a;
        for (int i = 0; i < TOTAL; i++) begin
            a = base + 16'(i);
            addr_q.push_back(a);
            data_q.push_back(sram[a]);
        end
    endtask

    // Drives one load (start in cycle 0) and records outputs for cycles 1..ncyc.
    // Inputs set in cycle n are sampled at the edge opening cycle n+1.
    task automatic run_load(input logic [15:0] base, input int ncyc,
                            input int hold_lo, input int hold_hi,
                            input int s_ign1, input int s_ign2, input int s_new);
        got_q.delete();
        @(posedge clk); #1;
        base_addr = base;
        start     = 1'b1;
        push_load(base);
        for (int rel = 1; rel <= ncyc; rel++) begin
            @(posedge clk); #1;
            rec_rd[rel]   = mem_rd_en;
            rec_pe[rel]   = pe_ready;
            rec_done[rel] = done;
            rec_busy[rel] = busy;
            rec_addr[rel] = mem_addr;
            start = (rel == s_ign1) || (rel == s_ign2) || (rel == s_new);
            hold  = (rel >= hold_lo) && (rel <= hold_hi);
            if (rel == s_new) push_load(base);
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b exp 0", mem_rd_en); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h exp 0000", mem_addr); end
        n_cmp++; if (kernal !== 16'h0000) begin n_err++; $display("FAIL rst_kernal: got %h exp 0000", kernal); end
        n_cmp++; if (pe_ready !== 1'b0) begin n_err++; $display("FAIL rst_pe_ready: got %b exp 0", pe_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b exp 0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Ramp load; hold raised only after FETCH (DRAIN/DONE/IDLE) must change nothing
    task automatic test_basic();
        logic e_rd [0:127];
        run_load(16'h0100, 45, 37, 44, -1, -1, -1);
        for (int r = 0; r < 128; r++) e_rd[r] = (r >= 1) && (r <= 36);
        for (int rel = 1; rel <= 45; rel++) begin
            n_cmp++; if (rec_rd[rel] !== e_rd[rel]) begin n_err++; $display("FAIL basic_rd cyc=%0d got=%b exp=%b", rel, rec_rd[rel], e_rd[rel]); end
            n_cmp++; if (rec_pe[rel] !== ((rel >= 3) ? e_rd[rel-2] : 1'b0)) begin n_err++; $display("FAIL basic_pe cyc=%0d got=%b", rel, rec_pe[rel]); end
            n_cmp++; if (rec_done[rel] !== (rel == 40)) begin n_err++; $display("FAIL basic_done cyc=%0d got=%b", rel, rec_done[rel]); end
            n_cmp++; if (rec_busy[rel] !== (rel <= 40)) begin n_err++; $display("FAIL basic_busy cyc=%0d got=%b", rel, rec_busy[rel]); end
        end
        n_cmp++; if (got_q.size() != TOTAL) begin n_err++; $display("FAIL basic_count: got %0d exp %0d", got_q.size(), TOTAL); end
        for (int i = 0; i < TOTAL; i++) begin
            if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== 16'(i + 1)) begin n_err++; $display("FAIL basic_buf idx=%0d got %h exp %h", i, got_q[i], 16'(i + 1)); end
            end
        end
    endtask

    // Hold sampled at the edges opening cycles 5..9: reads paused there, done slips to 45
    task automatic test_hold();
        logic e_rd [0:127];
        run_load(16'h0100, 50, 4, 8, -1, -1, -1);
        for (int r = 0; r < 128; r++) e_rd[r] = ((r >= 1) && (r <= 4)) || ((r >= 10) && (r <= 41));
        for (int rel = 1; rel <= 50; rel++) begin
            n_cmp++; if (rec_rd[rel] !== e_rd[rel]) begin n_err++; $display("FAIL hold_rd cyc=%0d got=%b exp=%b", rel, rec_rd[rel], e_rd[rel]); end
            n_cmp++; if (rec_pe[rel] !== ((rel >= 3) ? e_rd[rel-2] : 1'b0)) begin n_err++; $display("FAIL hold_pe cyc=%0d got=%b", rel, rec_pe[rel]); end
            n_cmp++; if (rec_done[rel] !== (rel == 45)) begin n_err++; $display("FAIL hold_done cyc=%0d got=%b", rel, rec_done[rel]); end
            if ((rel >= 5) && (rel <= 9)) begin
                n_cmp++; if (rec_addr[rel] !== 16'h0104) begin n_err++; $display("FAIL hold_addr cyc=%0d got %h exp 0104", rel, rec_addr[rel]); end
            end
        end
        n_cmp++; if (got_q.size() != TOTAL) begin n_err++; $display("FAIL hold_count: got %0d exp %0d", got_q.size(), TOTAL); end
    endtask

    task automatic test_wrap();
        run_load(16'hFFFE, 42, -1, -1, -1, -1, -1);
        n_cmp++; if (rec_addr[2] !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr2: got %h exp FFFF", rec_addr[2]); end
        n_cmp++; if (rec_addr[3] !== 16'h0000) begin n_err++; $display("FAIL wrap_addr3: got %h exp 0000", rec_addr[3]); end
        n_cmp++; if (rec_addr[36] !== 16'h0021) begin n_err++; $display("FAIL wrap_addr36: got %h exp 0021", rec_addr[36]); end
        n_cmp++; if (rec_done[40] !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b exp 1", rec_done[40]); end
        n_cmp++; if (got_q.size() != TOTAL) begin n_err++; $display("FAIL wrap_count: got %0d exp %0d", got_q.size(), TOTAL); end
        for (int i = 0; i < TOTAL; i++) begin
            if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== (16'hA000 + 16'(i))) begin n_err++; $display("FAIL wrap_order idx=%0d got %h", i, got_q[i]); end
            end
        end
    endtask

    // Starts in cycles 10 (FETCH) and 40 (DONE) ignored; start in 41 begins a new load
    task automatic test_back_to_back();
        logic e_rd [0:127];
        run_load(16'h0100, 85, -1, -1, 10, 40, 41);
        for (int r = 0; r < 128; r++) e_rd[r] = ((r >= 1) && (r <= 36)) || ((r >= 42) && (r <= 77));
        for (int rel = 1; rel <= 85; rel++) begin
            n_cmp++; if (rec_rd[rel] !== e_rd[rel]) begin n_err++; $display("FAIL b2b_rd cyc=%0d got=%b exp=%b", rel, rec_rd[rel], e_rd[rel]); end
            n_cmp++; if (rec_done[rel] !== ((rel == 40) || (rel == 81))) begin n_err++; $display("FAIL b2b_done cyc=%0d got=%b", rel, rec_done[rel]); end
            n_cmp++; if (rec_busy[rel] !== (((rel >= 1) && (rel <= 40)) || ((rel >= 42) && (rel <= 81)))) begin n_err++; $display("FAIL b2b_busy cyc=%0d got=%b", rel, rec_busy[rel]); end
        end
        n_cmp++; if (rec_addr[42] !== 16'h0100) begin n_err++; $display("FAIL b2b_addr42: got %h exp 0100", rec_addr[42]); end
        n_cmp++; if (got_q.size() != 2 * TOTAL) begin n_err++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), 2 * TOTAL); end
    endtask

    task automatic test_signed();
        run_load(16'h0200, 42, -1, -1, -1, -1, -1);
        n_cmp++; if (got_q.size() != TOTAL) begin n_err++; $display("FAIL signed_count: got %0d exp %0d", got_q.size(), TOTAL); end
        if (got_q.size() >= 3) begin
            n_cmp++; if (got_q[0] !== 16'h8000) begin n_err++; $display("FAIL signed_w0: got %h exp 8000", got_q[0]); end
            n_cmp++; if (got_q[1] !== 16'hFFFF) begin n_err++; $display("FAIL signed_w1: got %h exp FFFF", got_q[1]); end
            n_cmp++; if (got_q[2] !== 16'h7FFF) begin n_err++; $display("FAIL signed_w2: got %h exp 7FFF", got_q[2]); end
        end
    endtask

    task automatic test_midload_reset();
        @(posedge clk); #1;
        base_addr = 16'h0100;
        start     = 1'b1;
        push_load(16'h0100);
        for (int rel = 1; rel <= 20; rel++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL mrst_rd_en: got %b exp 0", mem_rd_en); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL mrst_addr: got %h exp 0000", mem_addr); end
        n_cmp++; if (kernal !== 16'h0000) begin n_err++; $display("FAIL mrst_kernal: got %h exp 0000", kernal); end
        n_cmp++; if (pe_ready !== 1'b0) begin n_err++; $display("FAIL mrst_pe_ready: got %b exp 0", pe_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mrst_done: got %b exp 0", done); end
        addr_q.delete();
        data_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_cmp++; if ((pe_ready | done | busy | mem_rd_en) !== 1'b0) begin n_err++; $display("FAIL mrst_quiet c=%0d pe=%b done=%b busy=%b rd=%b exp all 0", c, pe_ready, done, busy, mem_rd_en); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        hold      = 1'b0;
        base_addr = 16'h0000;
        for (int i = 0; i < TOTAL; i++) begin
            sram[16'h0100 + 16'(i)] = 16'(i + 1);
            sram[16'hFFFE + 16'(i)] = 16'hA000 + 16'(i);
            sram[16'h0200 + 16'(i)] = 16'h0300 + 16'(i);
        end
        sram[16'h0200] = 16'h8000;
        sram[16'h0201] = 16'hFFFF;
        sram[16'h0202] = 16'h7FFF;

        test_reset();
        test_basic();
        test_hold();
        test_wrap();
        test_back_to_back();
        test_signed();
        test_midload_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
